lpffir_sched: RTL and testbench

Packet-level scheduler that shares one `lpffir_axis` filter instance between `N_CH` AXI-Stream requesters. It grants the filter to one requester at a time, round-robin, and holds the grant until that requester's `tlast`. Before switching owners, it flushes the filter delay line with zero samples so that no history leaks between channels. Filter output is routed back to the granted channel's TX port. It sits between the per-channel stream sources and sinks and the single `lpffir_axis` instance.

---
 rtl/lpffir_sched.sv | 152 +++++++++++++++
 tb/tb_lpffir_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpffir_sched.sv
// Packet-level round-robin scheduler sharing one lpffir_axis filter between
// N_CH AXI-Stream requesters. The grant is held until tlast; on an owner change
// the filter delay line is flushed with zero beats so no history leaks across
// channels.
module lpffir_sched #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned FLUSH_LEN = 5
) (
  input  logic                      aclk_i,
  input  logic                      aresetn_i,
  input  logic [N_CH-1:0]           s_tvalid_i,
  output logic [N_CH-1:0]           s_tready_o,
  input  logic [16*N_CH-1:0]        s_tdata_i,
  input  logic [N_CH-1:0]           s_tlast_i,
  output logic [N_CH-1:0]           m_tvalid_o,
  input  logic [N_CH-1:0]           m_tready_i,
  output logic [15:0]               m_tdata_o,
  output logic                      m_tlast_o,
  output logic                      fir_tvalid_o,
  input  logic                      fir_tready_i,
  output logic [15:0]               fir_tdata_o,
  output logic                      fir_tlast_o,
  input  logic                      fir_tvalid_i,
  output logic                      fir_tready_o,
  input  logic [15:0]               fir_tdata_i,
  input  logic                      fir_tlast_i,
  output logic [$clog2(N_CH)-1:0]   grant_o,
  output logic                      busy_o,
  output logic                      flush_o
);

  localparam int unsigned GW = $clog2(N_CH);
  localparam int unsigned SW = GW + 1;
  localparam int unsigned CW = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {StIdle, StFlush, StStream} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            owner_vld_q, owner_vld_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [SW-1:0]   arb_sum;
  logic [15:0]     ch_data [N_CH];

  // Unpack the per-channel data bus so the owner can be selected by index.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_data[k] = s_tdata_i[16*k +: 16];
    end
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_sum   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + SW'(i);
      if (arb_sum >= SW'(N_CH)) begin
        arb_sum = arb_sum - SW'(N_CH);
      end
      if (!win_found && s_tvalid_i[arb_sum[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = arb_sum[GW-1:0];
      end
    end
  end

  // Next-state and stream routing; everything idles at zero outside FLUSH/STREAM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    owner_vld_d  = owner_vld_q;
    flush_cnt_d  = flush_cnt_q;
    s_tready_o   = '0;
    m_tvalid_o   = '0;
    m_tdata_o    = '0;
    m_tlast_o    = 1'b0;
    fir_tvalid_o = 1'b0;
    fir_tready_o = 1'b0;
    fir_tdata_o  = '0;
    fir_tlast_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_idx;
          // Dirty history from a different owner must be flushed first.
          if (owner_vld_q && (win_idx != grant_q)) begin
            state_d     = StFlush;
            flush_cnt_d = '0;
          end else begin
            state_d = StStream;
          end
        end
      end
      StFlush: begin
        fir_tvalid_o = 1'b1;
        fir_tready_o = 1'b1;
        if (fir_tready_i) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == CW'(FLUSH_LEN - 1)) begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        // Valid comes only from the source, never from any ready.
        fir_tvalid_o         = s_tvalid_i[grant_q];
        fir_tdata_o          = ch_data[grant_q];
        fir_tlast_o          = s_tlast_i[grant_q];
        fir_tready_o         = m_tready_i[grant_q];
        s_tready_o[grant_q]  = fir_tready_i;
        m_tvalid_o[grant_q]  = fir_tvalid_i;
        m_tdata_o            = fir_tdata_i;
        m_tlast_o            = fir_tlast_i;
        if (s_tvalid_i[grant_q] && fir_tready_i && s_tlast_i[grant_q]) begin
          state_d     = StIdle;
          owner_vld_d = 1'b1;
          rr_ptr_d    = (grant_q == GW'(N_CH - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset also clears the filter, so history is clean after it.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      owner_vld_q <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_vld_q <= owner_vld_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);
  assign flush_o = (state_q == StFlush);

endmodule

// File: tb/tb_lpffir_sched.sv
// Self-checking bench for lpffir_sched with a behavioural filter stand-in
// (running sum over the current sample and a FLUSH_LEN-deep history).
module tb_lpffir_sched;

  localparam int unsigned NCH = 3;
  localparam int unsigned FL  = 5;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NCH-1:0]    s_tvalid, s_tready, s_tlast, m_tvalid, m_tready;
  logic [16*NCH-1:0] s_tdata;
  logic [15:0]       m_tdata;
  logic              m_tlast;
  logic              fir_tvalid_o, fir_tready_i, fir_tlast_o;
  logic              fir_tvalid_i, fir_tready_o, fir_tlast_i;
  logic [15:0]       fir_tdata_o, fir_tdata_i;
  logic [1:0]        grant;
  logic              busy, flush;
  logic              fstall;

  always #5 aclk = ~aclk;

  lpffir_sched #(.N_CH(NCH), .FLUSH_LEN(FL)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata), .m_tlast_o(m_tlast),
    .fir_tvalid_o(fir_tvalid_o), .fir_tready_i(fir_tready_i), .fir_tdata_o(fir_tdata_o),
    .fir_tlast_o(fir_tlast_o), .fir_tvalid_i(fir_tvalid_i), .fir_tready_o(fir_tready_o),
    .fir_tdata_i(fir_tdata_i), .fir_tlast_i(fir_tlast_i),
    .grant_o(grant), .busy_o(busy), .flush_o(flush)
  );

  // Filter stand-in: combinational pass-through with an optional stall.
  logic [15:0] dl [FL];
  assign fir_tready_i = fir_tready_o & ~fstall;
  assign fir_tvalid_i = fir_tvalid_o & ~fstall;
  assign fir_tlast_i  = fir_tlast_o;
  always_comb begin
    fir_tdata_i = fir_tdata_o;
    for (int i = 0; i < FL; i++) fir_tdata_i = fir_tdata_i + dl[i];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FL; i++) dl[i] <= '0;
    end else if (fir_tvalid_o && fir_tready_i) begin
      dl[0] <= fir_tdata_o;
      for (int i = 1; i < FL; i++) dl[i] <= dl[i-1];
    end
  end

  // Reference model: phase 0 idle, 1 flushing, 2 streaming.
  int          m_phase, m_owner, m_ptr, m_fdone;
  bit          m_dirty;
  logic [15:0] sess [$];   // samples of the current clean session, newest first

  int total, bad;
  int txd [$];
  int txch [$];
  int lastch [$];
  int runs [$];
  int run;
  bit hs [NCH];
  logic [NCH-1:0] obs_srdy;
  logic obs_busy, obs_flush, obs_fv;
  logic [1:0] obs_grant;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    logic [NCH-1:0] e_sr, e_mv;
    logic e_fv, e_fr, e_fl, e_ml;
    logic [15:0] e_fd, e_md;
    bit chk_md;
    int g, w;
    e_sr = '0; e_mv = '0; e_fv = 0; e_fr = 0; e_fl = 0; e_ml = 0;
    e_fd = '0; e_md = '0; chk_md = 0;
    if (!aresetn) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_dirty = 0; sess.delete();
    end
    g = m_owner;
    if (m_phase == 0) begin
      chk_md = 1;
    end else if (m_phase == 1) begin
      e_fv = 1; e_fr = 1;
    end else begin
      e_fv = s_tvalid[g];
      e_fd = s_tdata[16*g +: 16];
      e_fl = s_tlast[g];
      e_fr = m_tready[g];
      e_sr[g] = m_tready[g] & ~fstall;
      e_mv[g] = s_tvalid[g] & ~fstall;
      e_md = e_fd;
      foreach (sess[i]) e_md = e_md + sess[i];
      e_ml = e_fl;
      if (e_mv[g]) chk_md = 1;
    end
    chk("fir_tvalid", fir_tvalid_o, e_fv);
    chk("fir_tready", fir_tready_o, e_fr);
    chk("fir_tdata", fir_tdata_o, e_fd);
    chk("fir_tlast", fir_tlast_o, e_fl);
    chk("s_tready", s_tready, e_sr);
    chk("m_tvalid", m_tvalid, e_mv);
    chk("busy", busy, m_phase != 0);
    chk("flush", flush, m_phase == 1);
    chk("grant", grant, g);
    if (chk_md) begin
      chk("m_tdata", m_tdata, e_md);
      chk("m_tlast", m_tlast, e_ml);
    end
    // Observations used by the drivers and the directed literal checks.
    obs_srdy = s_tready; obs_busy = busy; obs_flush = flush; obs_fv = fir_tvalid_o;
    obs_grant = grant;
    for (int k = 0; k < NCH; k++) begin
      hs[k] = s_tvalid[k] & s_tready[k];
      if (m_tvalid[k] && m_tready[k]) begin
        txd.push_back(int'(m_tdata)); txch.push_back(k);
        if (m_tlast) lastch.push_back(k);
      end
    end
    if (flush) run++;
    else if (run > 0) begin runs.push_back(run); run = 0; end
    // Advance the model.
    if (aresetn) begin
      if (m_phase == 0) begin
        w = -1;
        for (int i = 0; i < NCH; i++) begin
          if (w < 0 && s_tvalid[(m_ptr + i) % NCH]) w = (m_ptr + i) % NCH;
        end
        if (w >= 0) begin
          m_phase = (m_dirty && w != m_owner) ? 1 : 2;
          m_fdone = 0;
          m_owner = w;
        end
      end else if (m_phase == 1) begin
        if (!fstall) begin
          m_fdone++;
          if (m_fdone == FL) begin m_phase = 2; sess.delete(); end
        end
      end else if (s_tvalid[g] && m_tready[g] && !fstall) begin
        sess.push_front(s_tdata[16*g +: 16]);
        if (sess.size() > FL) void'(sess.pop_back());
        if (s_tlast[g]) begin m_phase = 0; m_dirty = 1; m_ptr = (g + 1) % NCH; end
      end
    end
  endtask

  task automatic step();
    @(negedge aclk);
    sample();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ch(int k, bit v, logic [15:0] d, bit l);
    s_tvalid[k] = v;
    s_tdata[16*k +: 16] = d;
    s_tlast[k] = l;
  endtask

  task automatic send(int k, logic [15:0] d, bit l);
    int n;
    n = 0;
    set_ch(k, 1'b1, d, l);
    do begin
      step();
      n++;
    end while (!hs[k] && n < 50);
    chk("send_handshake", hs[k], 1'b1);
    set_ch(k, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic clear_logs();
    txd.delete(); txch.delete(); lastch.delete(); runs.delete(); run = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    clear_logs();
  endtask

  task automatic chk_seq(string nm, int ch, int exp [$]);
    int got [$];
    foreach (txd[i]) if (txch[i] == ch) got.push_back(txd[i]);
    chk({nm, "_len"}, got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) chk($sformatf("%s_%0d", nm, i), got[i], exp[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e [$];
    int cnt [NCH];
    int idx;
    total = 0; bad = 0; run = 0;
    m_phase = 0; m_owner = 0; m_ptr = 0; m_dirty = 0; m_fdone = 0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = '1; fstall = 1'b0;
    #1;
    step();
    chk("rst_busy", obs_busy, 1'b0);
    chk("rst_flush", obs_flush, 1'b0);
    chk("rst_grant", obs_grant, 2'd0);
    chk("rst_fir_tvalid", obs_fv, 1'b0);
    aresetn = 1'b1;
    step();
    clear_logs();

    // Single packet on ch0.
    send(0, 16'd1, 1'b0); send(0, 16'd2, 1'b0); send(0, 16'd3, 1'b1);
    repeat (3) step();
    e = '{1, 3, 6};
    chk_seq("single", 0, e);
    chk("single_nflush", runs.size(), 0);

    // Owner change to ch1: exactly FL flush cycles, clean history.
    clear_logs();
    send(1, 16'd10, 1'b1);
    repeat (3) step();
    e = '{10};
    chk_seq("chg", 1, e);
    chk("chg_nflush", runs.size(), 1);
    if (runs.size() > 0) chk("chg_flen", runs[0], FL);

    // Same owner back-to-back: history carries over, no flush.
    do_reset();
    send(0, 16'd1, 1'b0); send(0, 16'd2, 1'b0); send(0, 16'd3, 1'b1);
    send(0, 16'd4, 1'b1);
    repeat (3) step();
    e = '{1, 3, 6, 10};
    chk_seq("same", 0, e);
    chk("same_nflush", runs.size(), 0);

    // Contention: ch0 and ch1 always valid with 2-beat packets.
    do_reset();
    for (int k = 0; k < NCH; k++) cnt[k] = 0;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 2; k++) set_ch(k, 1'b1, 16'(100 * k + cnt[k] + 1), cnt[k] % 2 == 1);
      step();
      for (int k = 0; k < 2; k++) if (hs[k]) cnt[k]++;
    end
    s_tvalid = '0;
    repeat (3) step();
    chk("cont_npk", lastch.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) if (i < lastch.size()) chk($sformatf("cont_grant_%0d", i), lastch[i], i % 2);
    chk("cont_nflush", runs.size() >= 3, 1'b1);
    for (int i = 0; i < 3; i++) if (i < runs.size()) chk($sformatf("cont_flen_%0d", i), runs[i], FL);

    // Backpressure on ch0 TX for 3 cycles mid-packet.
    do_reset();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      set_ch(0, idx < 5, 16'(idx + 1), idx == 4);
      m_tready[0] = !(c >= 3 && c <= 5);
      step();
      if (c >= 3 && c <= 5) chk($sformatf("bp_srdy_%0d", c), obs_srdy[0], 1'b0);
      if (hs[0]) idx++;
    end
    m_tready = '1;
    set_ch(0, 1'b0, 16'h0, 1'b0);
    repeat (2) step();
    e = '{1, 3, 6, 10, 15};
    chk_seq("bp", 0, e);

    // Reset on the 2nd flush beat; the following ch1 packet needs no flush.
    do_reset();
    send(0, 16'd7, 1'b1);
    set_ch(1, 1'b1, 16'd10, 1'b0);
    idx = 0;
    do begin step(); idx++; end while (!obs_flush && idx < 20);
    chk("rf_seen", obs_flush, 1'b1);
    aresetn = 1'b0;
    step();
    chk("rf_busy", obs_busy, 1'b0);
    chk("rf_flush", obs_flush, 1'b0);
    chk("rf_grant", obs_grant, 2'd0);
    chk("rf_fir_tvalid", obs_fv, 1'b0);
    aresetn = 1'b1;
    clear_logs();
    send(1, 16'd10, 1'b0); send(1, 16'd20, 1'b1);
    repeat (3) step();
    e = '{10, 30};
    chk_seq("rf", 1, e);
    chk("rf_nflush", runs.size(), 0);

    // Randomized traffic, backpressure, filter stalls and rare resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if (hs[k] || !s_tvalid[k]) begin
          set_ch(k, $urandom_range(0, 3) != 0, 16'($urandom_range(0, 255)),
                 $urandom_range(0, 3) == 0);
        end
        m_tready[k] = $urandom_range(0, 3) != 0;
      end
      fstall = $urandom_range(0, 4) == 0;
      aresetn = $urandom_range(0, 599) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
